// File: rtl/elbeth_memory_arbiter.sv
// ELBETH memory arbiter: shares one memory port between instruction fetch and data
// load/store with round-robin grant, word addressing, range check and access timeout.
module elbeth_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_imem_req,
    input  logic [31:0]           i_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_data,
    output logic                  o_imem_ready,
    output logic                  o_imem_error,

    input  logic                  i_dmem_req,
    input  logic [31:0]           i_dmem_addr,
    input  logic [DATA_WIDTH-1:0] i_dmem_wdata,
    input  logic [3:0]            i_dmem_rw,
    output logic [DATA_WIDTH-1:0] o_dmem_rdata,
    output logic                  o_dmem_ready,
    output logic                  o_dmem_error,

    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic [3:0]            o_mem_rw,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_error
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT_I = 2'd1;
    localparam logic [1:0] ST_GRANT_D = 2'd2;

    localparam int unsigned    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]            r_state;
    logic                  r_last_d;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_mem_en;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [3:0]            r_mem_rw;
    logic [DATA_WIDTH-1:0] r_imem_data;
    logic                  r_imem_ready;
    logic                  r_imem_error;
    logic [DATA_WIDTH-1:0] r_dmem_rdata;
    logic                  r_dmem_ready;
    logic                  r_dmem_error;

    logic        w_i_req;
    logic        w_d_req;
    logic        w_grant_i;
    logic        w_grant_d;
    logic [31:0] w_req_addr;
    logic        w_out_of_range;
    logic        w_is_d;
    logic        w_timeout;
    logic        w_done;
    logic        w_fail;
    logic [1:0]  w_unused_addr_bits;

    // A requester is ignored while its own completion pulse is out, so that a
    // req still high in its ready cycle is not taken as a fresh request.
    assign w_i_req   = i_imem_req & ~r_imem_ready & ~r_imem_error;
    assign w_d_req   = i_dmem_req & ~r_dmem_ready & ~r_dmem_error;
    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);
    assign w_grant_i = w_i_req & ~w_grant_d;

    assign w_req_addr         = w_grant_d ? i_dmem_addr : i_imem_addr;
    assign w_out_of_range     = |w_req_addr[31:ADDR_WIDTH+2];
    assign w_unused_addr_bits = w_req_addr[1:0];

    assign w_is_d    = (r_state == ST_GRANT_D);
    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_done    = i_mem_error | i_mem_ready | w_timeout;
    assign w_fail    = i_mem_error | ~i_mem_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_last_d     <= 1'b1;
            r_cnt        <= '0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_rw     <= 4'b0000;
            r_imem_data  <= '0;
            r_imem_ready <= 1'b0;
            r_imem_error <= 1'b0;
            r_dmem_rdata <= '0;
            r_dmem_ready <= 1'b0;
            r_dmem_error <= 1'b0;
        end else begin
            r_imem_ready <= 1'b0;
            r_imem_error <= 1'b0;
            r_dmem_ready <= 1'b0;
            r_dmem_error <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_grant_i || w_grant_d) begin
                        r_last_d <= w_grant_d;
                        if (w_out_of_range) begin
                            r_imem_error <= w_grant_i;
                            r_dmem_error <= w_grant_d;
                        end else begin
                            r_state     <= w_grant_d ? ST_GRANT_D : ST_GRANT_I;
                            r_mem_en    <= 1'b1;
                            r_mem_addr  <= w_req_addr[ADDR_WIDTH+1:2];
                            r_mem_wdata <= w_grant_d ? i_dmem_wdata : '0;
                            r_mem_rw    <= w_grant_d ? i_dmem_rw : 4'b0000;
                        end
                    end
                end

                ST_GRANT_I, ST_GRANT_D: begin
                    if (w_done) begin
                        r_state  <= ST_IDLE;
                        r_mem_en <= 1'b0;
                        r_cnt    <= '0;
                        // mem_error outranks mem_ready; a timeout leaves data untouched.
                        if (w_is_d) begin
                            r_dmem_ready <= ~w_fail;
                            r_dmem_error <= w_fail;
                            if (i_mem_error) begin
                                r_dmem_rdata <= '0;
                            end else if (i_mem_ready) begin
                                r_dmem_rdata <= i_mem_rdata;
                            end
                        end else begin
                            r_imem_ready <= ~w_fail;
                            r_imem_error <= w_fail;
                            if (i_mem_error) begin
                                r_imem_data <= '0;
                            end else if (i_mem_ready) begin
                                r_imem_data <= i_mem_rdata;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_data  = r_imem_data;
    assign o_imem_ready = r_imem_ready;
    assign o_imem_error = r_imem_error;
    assign o_dmem_rdata = r_dmem_rdata;
    assign o_dmem_ready = r_dmem_ready;
    assign o_dmem_error = r_dmem_error;
    assign o_mem_en     = r_mem_en;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_rw     = r_mem_rw;

endmodule
